// File: rtl/skyhop_pkg.sv
// Shared definitions for the SkyHop frame-synchronous game controllers.
package skyhop_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GROUND = 2'd1,
        RISE   = 2'd2,
        FALL   = 2'd3
    } state_t;

    localparam int SCREEN_W_DEF = 800;
    localparam int SCREEN_H_DEF = 600;

    // Top edge of a sprite standing on the ground line.
    function automatic int y_rest(input int ground_y, input int rect_h);
        return ground_y - rect_h;
    endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Registers vsync once and emits a one-cycle tick on its rising edge.
module vsync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_d_q;
    logic vsync_d_d;

    always_comb begin
        vsync_d_d = vsync_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d_q <= 1'b0;
        end else begin
            vsync_d_q <= vsync_d_d;
        end
    end

    assign tick = vsync_in & ~vsync_d_q;

endmodule

// File: rtl/rect_jump_ctl.sv
// Player rectangle motion: horizontal stepping, jump with gravity and edge
// clamping, all advanced once per frame on the vsync rising edge.
module rect_jump_ctl
    import skyhop_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int RECT_WIDTH  = 80,
    parameter int RECT_HEIGHT = 80,
    parameter int GROUND_Y    = 520,
    parameter int X_INIT      = 360,
    parameter int X_STEP      = 4,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int VMAX        = 15
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       enable,
    input  logic       jump,
    input  logic       left,
    input  logic       right,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       module_en,
    output logic       airborne
);

    // A ground line below the screen would park the sprite off-screen.
    localparam int Y_REST_RAW = y_rest(GROUND_Y, RECT_HEIGHT);
    localparam int Y_REST     = (Y_REST_RAW < SCREEN_H - RECT_HEIGHT) ?
                                Y_REST_RAW : SCREEN_H - RECT_HEIGHT;

    localparam logic [10:0] X_MAX_W  = 11'(SCREEN_W - RECT_WIDTH);
    localparam logic [10:0] X_STEP_W = 11'(X_STEP);
    localparam logic [10:0] Y_REST_W = 11'(Y_REST);
    localparam logic [9:0]  X_INIT_W = 10'(X_INIT);
    localparam logic [9:0]  Y_INIT_W = 10'(Y_REST);
    localparam logic [4:0]  JUMP_V_W = 5'(JUMP_V);
    localparam logic [4:0]  GRAV_W   = 5'(GRAVITY);
    localparam logic [5:0]  VMAX_W   = 6'(VMAX);

    logic       tick;
    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [4:0] vy_q, vy_d;
    logic       jump_req_q, jump_req_d;
    logic       module_en_q, module_en_d;
    logic       airborne_q, airborne_d;

    logic        jump_hit;
    logic [10:0] x_ext, y_ext, vy_ext, x_step_n, y_fall;
    logic [5:0]  vn_sum;
    logic [4:0]  vn;

    vsync_edge_det u_vsync_edge_det (
        .clk      (pclk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .tick     (tick)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= X_INIT_W;
            y_q         <= Y_INIT_W;
            vy_q        <= 5'd0;
            jump_req_q  <= 1'b0;
            module_en_q <= 1'b0;
            airborne_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            jump_req_q  <= jump_req_d;
            module_en_q <= module_en_d;
            airborne_q  <= airborne_d;
        end
    end

    // Horizontal step and fall arithmetic, 11 bits wide so nothing wraps.
    always_comb begin
        x_ext  = {1'b0, x_q};
        y_ext  = {1'b0, y_q};
        vy_ext = {6'd0, vy_q};

        x_step_n = x_ext;
        if (left && !right) begin
            x_step_n = (x_ext >= X_STEP_W) ? x_ext - X_STEP_W : 11'd0;
        end else if (right && !left) begin
            x_step_n = x_ext + X_STEP_W;
            if (x_step_n > X_MAX_W) begin
                x_step_n = X_MAX_W;
            end
        end

        vn_sum = {1'b0, vy_q} + {1'b0, GRAV_W};
        vn     = (vn_sum > VMAX_W) ? VMAX_W[4:0] : vn_sum[4:0];
        y_fall = y_ext + {6'd0, vn};
    end

    // A request raised in the tick cycle itself still counts at that tick.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        jump_hit   = jump_req_q | jump;
        jump_req_d = tick ? 1'b0 : jump_hit;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = GROUND;
                    x_d     = X_INIT_W;
                    y_d     = Y_INIT_W;
                    vy_d    = 5'd0;
                end
            end
            default: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    x_d = x_step_n[9:0];
                    case (state_q)
                        GROUND: begin
                            if (jump_hit) begin
                                vy_d    = JUMP_V_W;
                                state_d = RISE;
                            end
                        end
                        RISE: begin
                            if (y_ext <= vy_ext) begin
                                y_d     = 10'd0;
                                vy_d    = 5'd0;
                                state_d = FALL;
                            end else begin
                                y_d = 10'(y_ext - vy_ext);
                                if (vy_q > GRAV_W) begin
                                    vy_d = vy_q - GRAV_W;
                                end else begin
                                    vy_d    = 5'd0;
                                    state_d = FALL;
                                end
                            end
                        end
                        FALL: begin
                            if (y_fall >= Y_REST_W) begin
                                y_d     = Y_INIT_W;
                                vy_d    = 5'd0;
                                state_d = GROUND;
                            end else begin
                                y_d  = y_fall[9:0];
                                vy_d = vn;
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        module_en_d = (state_d != IDLE);
        airborne_d  = (state_d == RISE) || (state_d == FALL);
    end

    assign xpos      = x_q;
    assign ypos      = y_q;
    assign module_en = module_en_q;
    assign airborne  = airborne_q;

endmodule

// File: tb/tb_rect_jump_ctl.sv
// Directed bench for rect_jump_ctl: a default instance and a low-ceiling one.
module tb_rect_jump_ctl;

    logic       pclk = 1'b0;
    logic       rst, rst2;
    logic       vsync_in;
    logic       enable, enable2;
    logic       jump, jump2;
    logic       left, right;
    logic [9:0] xpos, ypos, xpos2, ypos2;
    logic       module_en, airborne, module_en2, airborne2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    rect_jump_ctl u_dut (
        .pclk      (pclk),
        .rst       (rst),
        .vsync_in  (vsync_in),
        .enable    (enable),
        .jump      (jump),
        .left      (left),
        .right     (right),
        .xpos      (xpos),
        .ypos      (ypos),
        .module_en (module_en),
        .airborne  (airborne)
    );

    rect_jump_ctl #(
        .GROUND_Y    (100),
        .RECT_HEIGHT (80),
        .JUMP_V      (30)
    ) u_ceil (
        .pclk      (pclk),
        .rst       (rst2),
        .vsync_in  (vsync_in),
        .enable    (enable2),
        .jump      (jump2),
        .left      (left),
        .right     (right),
        .xpos      (xpos2),
        .ypos      (ypos2),
        .module_en (module_en2),
        .airborne  (airborne2)
    );

    typedef struct {
        logic       l;
        logic       r;
        logic       j;
        logic [9:0] exp_x;
        logic [9:0] exp_y;
        logic       exp_air;
    } vec_t;

    vec_t vecs[28];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Rising vsync with an optional jump in the same cycle; sampled two cycles later.
    task automatic do_tick(input logic with_jump);
        @(negedge pclk);
        vsync_in = 1'b1;
        if (with_jump) jump = 1'b1;
        @(negedge pclk);
        vsync_in = 1'b0;
        jump     = 1'b0;
        @(negedge pclk);
    endtask

    task automatic pulse_jump();
        @(negedge pclk);
        jump = 1'b1;
        @(negedge pclk);
        jump = 1'b0;
    endtask

    task automatic fill_vecs();
        logic [9:0] ys[28];
        ys = '{440, 428, 417, 407, 398, 390, 383, 377, 372, 368, 365, 363, 362,
               363, 365, 368, 372, 377, 383, 390, 398, 407, 417, 428, 440,
               440, 440, 440};
        for (int i = 0; i < 28; i++) begin
            vecs[i] = '{l: 1'b0, r: 1'b0, j: 1'b0, exp_x: 10'd364,
                        exp_y: ys[i], exp_air: (i >= 1 && i <= 23) || i == 0};
        end
        vecs[0].j = 1'b1; vecs[0].exp_x = 10'd360;
        vecs[1].r = 1'b1; vecs[1].exp_x = 10'd364;
        vecs[2].r = 1'b1; vecs[2].exp_x = 10'd368;
        vecs[3].r = 1'b1; vecs[3].exp_x = 10'd372;
        vecs[4].l = 1'b1; vecs[4].exp_x = 10'd368;
        vecs[5].l = 1'b1; vecs[5].exp_x = 10'd364;
        vecs[6].l = 1'b1; vecs[6].r = 1'b1;
        vecs[24].exp_air = 1'b0;
        vecs[25].r = 1'b1; vecs[25].exp_x = 10'd368;
        vecs[26].l = 1'b1; vecs[26].exp_x = 10'd364;
    endtask

    initial begin
        logic bad;
        rst = 1'b1; rst2 = 1'b1; vsync_in = 1'b0;
        enable = 1'b0; enable2 = 1'b0; jump = 1'b0; jump2 = 1'b0;
        left = 1'b0; right = 1'b0;
        fill_vecs();
        repeat (3) @(negedge pclk);
        check("reset_x", xpos, 10'd360);
        check("reset_y", ypos, 10'd440);
        check("reset_en", {9'd0, module_en}, 10'd0);
        check("reset_air", {9'd0, airborne}, 10'd0);
        rst = 1'b0;
        @(negedge pclk);
        check("idle_en", {9'd0, module_en}, 10'd0);
        enable = 1'b1;
        @(negedge pclk);
        check("spawn_x", xpos, 10'd360);
        check("spawn_y", ypos, 10'd440);
        check("spawn_en", {9'd0, module_en}, 10'd1);
        check("spawn_air", {9'd0, airborne}, 10'd0);

        // Jump arc with mixed horizontal input; row 0 has jump on the tick itself.
        for (int i = 0; i < 28; i++) begin
            left  = vecs[i].l;
            right = vecs[i].r;
            do_tick(vecs[i].j);
            check($sformatf("vec%0d_x", i), xpos, vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), ypos, vecs[i].exp_y);
            check($sformatf("vec%0d_air", i), {9'd0, airborne}, {9'd0, vecs[i].exp_air});
            check($sformatf("vec%0d_en", i), {9'd0, module_en}, 10'd1);
        end
        left = 1'b0; right = 1'b0;

        // Separate pulse, then a jump pressed during FALL must be discarded.
        pulse_jump();
        do_tick(1'b0);
        check("pulse_rise_air", {9'd0, airborne}, 10'd1);
        check("pulse_rise_y", ypos, 10'd440);
        do_tick(1'b0);
        check("pulse_t1_y", ypos, 10'd428);
        repeat (12) do_tick(1'b0);
        check("fall_t13_y", ypos, 10'd363);
        pulse_jump();
        repeat (11) do_tick(1'b0);
        check("land_y", ypos, 10'd440);
        check("land_air", {9'd0, airborne}, 10'd0);
        do_tick(1'b0);
        check("no_double_air", {9'd0, airborne}, 10'd0);
        check("no_double_y", ypos, 10'd440);

        // Right edge saturation from 364, then left down to zero without wrap.
        bad = 1'b0;
        right = 1'b1;
        for (int i = 0; i < 200; i++) begin
            do_tick(1'b0);
            if (xpos > 10'd720) bad = 1'b1;
        end
        check("right_sat_x", xpos, 10'd720);
        check("right_bound", {9'd0, bad}, 10'd0);
        right = 1'b0; left = 1'b1;
        for (int i = 0; i < 200; i++) begin
            do_tick(1'b0);
            if (xpos > 10'd720) bad = 1'b1;
        end
        check("left_sat_x", xpos, 10'd0);
        check("left_no_wrap", {9'd0, bad}, 10'd0);
        left = 1'b0;

        // Disable mid-RISE freezes ypos; re-enable respawns.
        do_tick(1'b1);
        do_tick(1'b0);
        check("pre_dis_y", ypos, 10'd428);
        @(negedge pclk);
        enable = 1'b0;
        @(negedge pclk);
        check("dis_en", {9'd0, module_en}, 10'd0);
        check("dis_air", {9'd0, airborne}, 10'd0);
        check("dis_y", ypos, 10'd428);
        do_tick(1'b0);
        check("dis_tick_y", ypos, 10'd428);
        check("dis_tick_x", xpos, 10'd0);
        enable = 1'b1;
        @(negedge pclk);
        check("reen_x", xpos, 10'd360);
        check("reen_y", ypos, 10'd440);
        check("reen_en", {9'd0, module_en}, 10'd1);
        check("reen_air", {9'd0, airborne}, 10'd0);

        // Low ceiling: first RISE tick clamps to 0, then reset during FALL.
        rst2 = 1'b0;
        enable2 = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        check("ceil_rest_y", ypos2, 10'd20);
        check("ceil_en", {9'd0, module_en2}, 10'd1);
        @(negedge pclk);
        vsync_in = 1'b1; jump2 = 1'b1;
        @(negedge pclk);
        vsync_in = 1'b0; jump2 = 1'b0;
        @(negedge pclk);
        check("ceil_rise_air", {9'd0, airborne2}, 10'd1);
        check("ceil_rise_y", ypos2, 10'd20);
        do_tick(1'b0);
        check("ceil_clamp_y", ypos2, 10'd0);
        check("ceil_clamp_air", {9'd0, airborne2}, 10'd1);
        do_tick(1'b0);
        check("ceil_fall_y", ypos2, 10'd1);
        rst2 = 1'b1;
        @(negedge pclk);
        check("rst_fall_x", xpos2, 10'd360);
        check("rst_fall_y", ypos2, 10'd20);
        check("rst_fall_en", {9'd0, module_en2}, 10'd0);
        check("rst_fall_air", {9'd0, airborne2}, 10'd0);
        check("main_undisturbed_y", ypos, 10'd440);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
